fifo_sync_rv: RTL and testbench

- Next-generation synchronous FIFO with valid/ready handshakes on both sides.
- Supports any DEPTH ≥ 2, including non-power-of-2 depths, using wrap-at-DEPTH pointers.
- Provides an exact occupancy count and a synchronous flush.
- Optional registered output stage for timing closure; drop-in buffer for streaming datapaths.

---
 rtl/fifo_sync_rv.sv | 215 +++++++++++++++++++++
 tb/tb_fifo_sync_rv.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_rv.sv
// Synchronous valid/ready FIFO with wrap-at-DEPTH pointers, exact occupancy count,
// synchronous flush and an optional registered head-of-queue output stage.

module fifo_sync_rv_chk #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned CW            = 5,
    parameter int unsigned CAP           = 16,
    parameter string       INSTANCE_NAME = "DEADF1F0"
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    input  logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [CW-1:0]         count
);

    logic                  stall_r;
    logic [DATA_WIDTH-1:0] held_data_r;

    // Remember whether the producer was stalled last cycle and what it offered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_r     <= 1'b0;
            held_data_r <= {DATA_WIDTH{1'b0}};
        end else begin
            stall_r     <= wr_valid & ~wr_ready;
            held_data_r <= wr_data;
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count <= CW'(CAP))
        else $error("%s: occupancy %0d exceeds capacity %0d", INSTANCE_NAME, count, CAP);

    a_wr_data_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (stall_r & wr_valid) |-> (wr_data == held_data_r))
        else $warning("%s: write data changed while stalled", INSTANCE_NAME);

endmodule

module fifo_sync_rv #(
    parameter int unsigned DATA_WIDTH       = 8,
    parameter int unsigned DEPTH            = 16,
    parameter int unsigned ALMOST_WR_MARGIN = 1,
    parameter int unsigned ALMOST_RD_MARGIN = 1,
    parameter int unsigned REGISTERED       = 0,
    parameter string       INSTANCE_NAME    = "DEADF1F0"
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_flush,
    input  logic                          i_wr_valid,
    output logic                          o_wr_ready,
    input  logic [DATA_WIDTH-1:0]         i_wr_data,
    output logic                          o_rd_valid,
    input  logic                          i_rd_ready,
    output logic [DATA_WIDTH-1:0]         o_rd_data,
    output logic [$clog2(DEPTH+2)-1:0]    o_count,
    output logic                          o_almost_full,
    output logic                          o_almost_empty
);

    localparam int unsigned CW       = $clog2(DEPTH + 2);
    localparam int unsigned PW       = $clog2(DEPTH);
    localparam int unsigned CAP      = DEPTH + REGISTERED;
    localparam logic [CW-1:0] CAP_C  = CW'(CAP);
    localparam logic AF_RESET        = (CAP <= ALMOST_WR_MARGIN) ? 1'b1 : 1'b0;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]         wr_ptr_r;
    logic [PW-1:0]         rd_ptr_r;
    logic [CW-1:0]         count_r;
    logic [CW-1:0]         count_next_s;
    logic [31:0]           free_next_s;
    logic                  rd_valid_r;
    logic                  almost_full_r;
    logic                  almost_empty_r;
    logic                  wr_ready_s;
    logic                  wr_fire_s;
    logic                  rd_fire_s;
    logic                  mem_wr_s;
    logic                  mem_rd_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        if (ptr == PW'(DEPTH - 1)) begin
            return {PW{1'b0}};
        end else begin
            return ptr + PW'(1);
        end
    endfunction

    // No pass-through at full: a read in the same cycle does not open the write side
    assign wr_ready_s = (count_r != CAP_C) & ~i_flush;
    assign wr_fire_s  = i_wr_valid & wr_ready_s;
    assign rd_fire_s  = rd_valid_r & i_rd_ready;

    // Next occupancy and the free space it leaves
    always_comb begin
        count_next_s = count_r;
        if (i_flush) begin
            count_next_s = {CW{1'b0}};
        end else if (wr_fire_s & ~rd_fire_s) begin
            count_next_s = count_r + CW'(1);
        end else if (~wr_fire_s & rd_fire_s) begin
            count_next_s = count_r - CW'(1);
        end else begin
            count_next_s = count_r;
        end
        free_next_s = 32'(CAP) - 32'(count_next_s);
    end

    // Occupancy and status flags, all registered from the next count
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_r        <= {CW{1'b0}};
            rd_valid_r     <= 1'b0;
            almost_full_r  <= AF_RESET;
            almost_empty_r <= 1'b0;
        end else begin
            count_r        <= count_next_s;
            rd_valid_r     <= (count_next_s != {CW{1'b0}});
            almost_full_r  <= (free_next_s <= ALMOST_WR_MARGIN);
            almost_empty_r <= (count_next_s != {CW{1'b0}}) &&
                              (32'(count_next_s) <= ALMOST_RD_MARGIN);
        end
    end

    // Memory pointers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
        end else if (i_flush) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
        end else begin
            if (mem_wr_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (mem_rd_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
        end
    end

    // Storage array, intentionally not reset
    always_ff @(posedge i_clk) begin
        if (mem_wr_s) begin
            mem_r[wr_ptr_r] <= i_wr_data;
        end
    end

    generate
        if (REGISTERED == 0) begin : g_comb_out
            assign mem_wr_s  = wr_fire_s;
            assign mem_rd_s  = rd_fire_s;
            assign o_rd_data = mem_r[rd_ptr_r];
        end else begin : g_reg_out
            logic                  out_valid_r;
            logic [DATA_WIDTH-1:0] out_data_r;
            logic [CW-1:0]         mem_cnt_s;
            logic                  mem_empty_s;
            logic                  out_load_s;
            logic                  bypass_s;

            // The output flop holds the head; memory holds everything behind it
            assign mem_cnt_s   = count_r - CW'(out_valid_r);
            assign mem_empty_s = (mem_cnt_s == {CW{1'b0}});
            assign out_load_s  = ~out_valid_r | rd_fire_s;
            assign mem_rd_s    = out_load_s & ~mem_empty_s;
            assign bypass_s    = out_load_s & mem_empty_s & wr_fire_s;
            assign mem_wr_s    = wr_fire_s & ~bypass_s;
            assign o_rd_data   = out_data_r;

            // Head-of-queue output stage with write bypass when memory is empty
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    out_valid_r <= 1'b0;
                    out_data_r  <= {DATA_WIDTH{1'b0}};
                end else if (i_flush) begin
                    out_valid_r <= 1'b0;
                end else if (mem_rd_s) begin
                    out_valid_r <= 1'b1;
                    out_data_r  <= mem_r[rd_ptr_r];
                end else if (bypass_s) begin
                    out_valid_r <= 1'b1;
                    out_data_r  <= i_wr_data;
                end else if (out_load_s) begin
                    out_valid_r <= 1'b0;
                end
            end
        end
    endgenerate

    assign o_wr_ready     = wr_ready_s;
    assign o_rd_valid     = rd_valid_r;
    assign o_count        = count_r;
    assign o_almost_full  = almost_full_r;
    assign o_almost_empty = almost_empty_r;

    fifo_sync_rv_chk #(
        .DATA_WIDTH    (DATA_WIDTH),
        .CW            (CW),
        .CAP           (CAP),
        .INSTANCE_NAME (INSTANCE_NAME)
    ) u_chk (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .wr_valid (i_wr_valid),
        .wr_ready (wr_ready_s),
        .wr_data  (i_wr_data),
        .count    (count_r)
    );

endmodule

// File: tb/tb_fifo_sync_rv.sv
// Directed bench: instance A is DEPTH=5 combinational output, instance B is DEPTH=4 registered output.
module tb_fifo_sync_rv;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         checks = 0;
    int         failures = 0;

    logic       a_flush, a_wr_valid, a_wr_ready, a_rd_valid, a_rd_ready, a_af, a_ae;
    logic [7:0] a_wr_data, a_rd_data;
    logic [2:0] a_count;
    logic       b_flush, b_wr_valid, b_wr_ready, b_rd_valid, b_rd_ready, b_af, b_ae;
    logic [7:0] b_wr_data, b_rd_data;
    logic [2:0] b_count;

    always #5 clk = ~clk;

    fifo_sync_rv #(.DATA_WIDTH(8), .DEPTH(5), .REGISTERED(0), .INSTANCE_NAME("FIFO_A")) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(a_flush),
        .i_wr_valid(a_wr_valid), .o_wr_ready(a_wr_ready), .i_wr_data(a_wr_data),
        .o_rd_valid(a_rd_valid), .i_rd_ready(a_rd_ready), .o_rd_data(a_rd_data),
        .o_count(a_count), .o_almost_full(a_af), .o_almost_empty(a_ae));

    fifo_sync_rv #(.DATA_WIDTH(8), .DEPTH(4), .REGISTERED(1), .INSTANCE_NAME("FIFO_B")) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(b_flush),
        .i_wr_valid(b_wr_valid), .o_wr_ready(b_wr_ready), .i_wr_data(b_wr_data),
        .o_rd_valid(b_rd_valid), .i_rd_ready(b_rd_ready), .o_rd_data(b_rd_data),
        .o_count(b_count), .o_almost_full(b_af), .o_almost_empty(b_ae));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        a_flush = 1'b0; a_wr_valid = 1'b0; a_rd_ready = 1'b0; a_wr_data = 8'h00;
        b_flush = 1'b0; b_wr_valid = 1'b0; b_rd_ready = 1'b0; b_wr_data = 8'h00;
        rst_n = 1'b0;
        #22;
        checks++; if (a_rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%0b exp=0", a_rd_valid); end
        checks++; if (a_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", a_count); end
        checks++; if (a_af !== 1'b0 || a_ae !== 1'b0) begin failures++; $display("FAIL reset_flags got af=%0b ae=%0b exp 0 0", a_af, a_ae); end
        checks++; if (a_wr_ready !== 1'b1) begin failures++; $display("FAIL reset_wr_ready got=%0b exp=1", a_wr_ready); end
        checks++; if (b_rd_valid !== 1'b0 || b_rd_data !== 8'h00) begin failures++; $display("FAIL reset_b_out got valid=%0b data=%0h exp 0 00", b_rd_valid, b_rd_data); end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_fill_drain;
        for (int i = 0; i < 5; i++) begin
            a_wr_valid = 1'b1; a_wr_data = 8'h11 + 8'(i);
            tick;
            checks++; if (a_count !== 3'(i + 1)) begin failures++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, a_count, i + 1); end
            checks++; if (a_af !== ((i + 1) >= 4)) begin failures++; $display("FAIL fill_af[%0d] got=%0b exp=%0b", i, a_af, (i + 1) >= 4); end
            checks++; if (a_wr_ready !== (i < 4)) begin failures++; $display("FAIL fill_wr_ready[%0d] got=%0b exp=%0b", i, a_wr_ready, i < 4); end
        end
        a_wr_data = 8'h16;
        tick;
        a_wr_valid = 1'b0;
        checks++; if (a_count !== 3'd5) begin failures++; $display("FAIL full_hold_count got=%0d exp=5", a_count); end
        a_rd_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (a_rd_valid !== 1'b1 || a_rd_data !== 8'h11 + 8'(i)) begin failures++; $display("FAIL drain_data[%0d] got valid=%0b data=%0h exp 1 %0h", i, a_rd_valid, a_rd_data, 8'h11 + 8'(i)); end
            checks++; if (a_ae !== (i == 4)) begin failures++; $display("FAIL drain_ae[%0d] got=%0b exp=%0b", i, a_ae, i == 4); end
            tick;
        end
        a_rd_ready = 1'b0;
        checks++; if (a_rd_valid !== 1'b0 || a_count !== 3'd0) begin failures++; $display("FAIL drain_empty got valid=%0b count=%0d exp 0 0", a_rd_valid, a_count); end
    endtask

    task automatic test_wrap;
        int w = 0;
        int r = 0;
        for (int k = 0; k < 3; k++) begin
            a_wr_valid = 1'b1; a_wr_data = 8'h40 + 8'(w);
            tick; w++;
        end
        a_rd_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            a_wr_data = 8'h40 + 8'(w);
            checks++; if (a_rd_data !== 8'h40 + 8'(r)) begin failures++; $display("FAIL wrap_data[%0d] got=%0h exp=%0h", r, a_rd_data, 8'h40 + 8'(r)); end
            tick; w++; r++;
            checks++; if (a_count !== 3'd3) begin failures++; $display("FAIL wrap_count[%0d] got=%0d exp=3", k, a_count); end
        end
        a_wr_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (a_rd_data !== 8'h40 + 8'(r)) begin failures++; $display("FAIL wrap_tail[%0d] got=%0h exp=%0h", r, a_rd_data, 8'h40 + 8'(r)); end
            tick; r++;
        end
        a_rd_ready = 1'b0;
        checks++; if (a_rd_valid !== 1'b0 || a_count !== 3'd0) begin failures++; $display("FAIL wrap_empty got valid=%0b count=%0d exp 0 0", a_rd_valid, a_count); end
    endtask

    task automatic test_full_rw;
        int w = 5;
        for (int i = 0; i < 5; i++) begin
            a_wr_valid = 1'b1; a_wr_data = 8'h50 + 8'(i);
            tick;
        end
        a_rd_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            a_wr_data = 8'h50 + 8'(w);
            checks++; if (a_wr_ready !== (k != 0)) begin failures++; $display("FAIL fullrw_wr_ready[%0d] got=%0b exp=%0b", k, a_wr_ready, k != 0); end
            checks++; if (a_rd_data !== 8'h50 + 8'(k)) begin failures++; $display("FAIL fullrw_data[%0d] got=%0h exp=%0h", k, a_rd_data, 8'h50 + 8'(k)); end
            tick;
            if (k != 0) w++;
            checks++; if (a_count !== 3'd4) begin failures++; $display("FAIL fullrw_count[%0d] got=%0d exp=4", k, a_count); end
        end
        a_wr_valid = 1'b0;
        for (int k = 6; k < 10; k++) begin
            checks++; if (a_rd_data !== 8'h50 + 8'(k)) begin failures++; $display("FAIL fullrw_tail[%0d] got=%0h exp=%0h", k, a_rd_data, 8'h50 + 8'(k)); end
            tick;
        end
        a_rd_ready = 1'b0;
        checks++; if (a_count !== 3'd0) begin failures++; $display("FAIL fullrw_empty got=%0d exp=0", a_count); end
    endtask

    task automatic test_flush;
        for (int i = 0; i < 3; i++) begin
            a_wr_valid = 1'b1; a_wr_data = 8'h61 + 8'(i);
            tick;
        end
        checks++; if (a_count !== 3'd3) begin failures++; $display("FAIL flush_pre_count got=%0d exp=3", a_count); end
        a_flush = 1'b1; a_wr_data = 8'h64;
        #1;
        checks++; if (a_wr_ready !== 1'b0) begin failures++; $display("FAIL flush_wr_ready got=%0b exp=0", a_wr_ready); end
        tick;
        a_flush = 1'b0; a_wr_valid = 1'b0;
        checks++; if (a_count !== 3'd0 || a_rd_valid !== 1'b0) begin failures++; $display("FAIL flush_clear got count=%0d valid=%0b exp 0 0", a_count, a_rd_valid); end
        a_wr_valid = 1'b1; a_wr_data = 8'h70;
        tick;
        a_wr_valid = 1'b0;
        checks++; if (a_count !== 3'd1 || a_rd_data !== 8'h70) begin failures++; $display("FAIL flush_after got count=%0d data=%0h exp 1 70", a_count, a_rd_data); end
        a_rd_ready = 1'b1;
        tick;
        a_rd_ready = 1'b0;
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 2; i++) begin
            a_wr_valid = 1'b1; a_wr_data = 8'h81 + 8'(i);
            tick;
        end
        a_wr_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (a_rd_valid !== 1'b0 || a_count !== 3'd0) begin failures++; $display("FAIL async_reset got valid=%0b count=%0d exp 0 0", a_rd_valid, a_count); end
        #3 rst_n = 1'b1;
        tick;
        a_wr_valid = 1'b1; a_wr_data = 8'h3C;
        tick;
        a_wr_valid = 1'b0;
        checks++; if (a_rd_valid !== 1'b1 || a_rd_data !== 8'h3C || a_count !== 3'd1) begin failures++; $display("FAIL post_reset got valid=%0b data=%0h count=%0d exp 1 3c 1", a_rd_valid, a_rd_data, a_count); end
        a_rd_ready = 1'b1;
        tick;
        a_rd_ready = 1'b0;
    endtask

    task automatic test_registered_bypass;
        b_wr_valid = 1'b1; b_wr_data = 8'hA5;
        tick;
        b_wr_valid = 1'b0;
        checks++; if (b_rd_valid !== 1'b1 || b_rd_data !== 8'hA5 || b_count !== 3'd1) begin failures++; $display("FAIL bypass_out got valid=%0b data=%0h count=%0d exp 1 a5 1", b_rd_valid, b_rd_data, b_count); end
        checks++; if (u_b.wr_ptr_r !== 2'd0 || u_b.rd_ptr_r !== 2'd0) begin failures++; $display("FAIL bypass_ptrs got wr=%0d rd=%0d exp 0 0", u_b.wr_ptr_r, u_b.rd_ptr_r); end
        for (int i = 0; i < 4; i++) begin
            b_wr_valid = 1'b1; b_wr_data = 8'hA6 + 8'(i);
            tick;
            checks++; if (b_count !== 3'(i + 2) || b_rd_data !== 8'hA5) begin failures++; $display("FAIL bfill[%0d] got count=%0d data=%0h exp %0d a5", i, b_count, b_rd_data, i + 2); end
        end
        b_wr_valid = 1'b0;
        checks++; if (b_wr_ready !== 1'b0 || b_af !== 1'b1) begin failures++; $display("FAIL bfull got ready=%0b af=%0b exp 0 1", b_wr_ready, b_af); end
        b_rd_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (b_rd_valid !== 1'b1 || b_rd_data !== 8'hA5 + 8'(i)) begin failures++; $display("FAIL bdrain[%0d] got valid=%0b data=%0h exp 1 %0h", i, b_rd_valid, b_rd_data, 8'hA5 + 8'(i)); end
            tick;
        end
        b_rd_ready = 1'b0;
        checks++; if (b_rd_valid !== 1'b0 || b_count !== 3'd0) begin failures++; $display("FAIL bdrain_empty got valid=%0b count=%0d exp 0 0", b_rd_valid, b_count); end
        b_wr_valid = 1'b1; b_wr_data = 8'hB1;
        tick;
        b_wr_data = 8'hB2; b_rd_ready = 1'b1;
        checks++; if (b_rd_data !== 8'hB1) begin failures++; $display("FAIL bsim_head got=%0h exp=b1", b_rd_data); end
        tick;
        b_wr_valid = 1'b0; b_rd_ready = 1'b0;
        checks++; if (b_rd_valid !== 1'b1 || b_rd_data !== 8'hB2 || b_count !== 3'd1) begin failures++; $display("FAIL bsim_next got valid=%0b data=%0h count=%0d exp 1 b2 1", b_rd_valid, b_rd_data, b_count); end
        b_rd_ready = 1'b1;
        tick;
        b_rd_ready = 1'b0;
        checks++; if (b_count !== 3'd0) begin failures++; $display("FAIL bfinal_count got=%0d exp=0", b_count); end
    endtask

    initial begin
        test_reset;
        test_fill_drain;
        test_wrap;
        test_full_rw;
        test_flush;
        test_registered_bypass;
        test_async_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
